uart_rx_word_packer: RTL and testbench
======================================

Name: uart_rx_word_packer

Overview:
- Sits between the UART receiver and the MIPS core's UART data input.
- Takes the receiver's byte-valid strobe and byte, which arrive from the UART clock domain.
- Synchronises the strobe into the core clock domain and packs BYTES consecutive bytes, little-endian, into one BIT_WIDTH word.
- Presents the word to the core with a valid/ack handshake, an inter-byte timeout, and sticky error flags.

Parameters:
- BIT_WIDTH, 32, width of the assembled word; must be a multiple of 8.
- BYTES, BIT_WIDTH/8, number of bytes per word.
- CNT_W, $clog2(BYTES), width of the byte counter.
- SYNC_STAGES, 2, flops in the rx_dv synchroniser; minimum 2.
- TIMEOUT_CYC, 50000, number of clk cycles without a new byte before a partial word is discarded.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- rx_dv  in  1  byte-valid from the UART receiver; asynchronous to clk; high for at least 1 UART clock
- rx_byte  in  8  received byte; stable from rx_dv rise until the next frame completes
- word_ack  in  1  core has consumed word_data
- clr_err  in  1  clears overflow and timeout_err
- word_data  out  BIT_WIDTH  assembled word; first byte received in [7:0]
- word_valid  out  1  word_data holds an unconsumed word
- byte_cnt  out  CNT_W  bytes held in the partial assembly
- overflow  out  1  sticky: a completed word was dropped
- timeout_err  out  1  sticky: a partial word was discarded on timeout

Behaviour:
- Reset (synchronous, clk rising edge with rst=1) clears:
  - all outputs to 0;
  - synchroniser flops and the edge-detect flop;
  - the assembly register, the timer, and the FSM, which returns to IDLE.
- Reset mid-word discards the partial bytes with no flag.
- Synchroniser and byte strobe:
  - rx_dv passes through SYNC_STAGES flops.
  - byte_stb = sync_last & ~sync_prev, one clk cycle per rx_dv rise.
  - rx_byte is sampled on the byte_stb cycle.
  - Latency: the rising edge that first samples rx_dv=1 is edge 0; the byte is captured at edge SYNC_STAGES (edge 2 by default).
- FSM has two states:
  - IDLE: byte_cnt=0, timer held at 0. On byte_stb, store the byte in lane 0, set byte_cnt=1, go to COLLECT. When BYTES=1, the word completes immediately instead.
  - COLLECT: on byte_stb, store the byte in lane byte_cnt and increment byte_cnt. On the byte that fills lane BYTES-1, the word completes, byte_cnt wraps to 0, and the FSM goes to IDLE.
- Timer (COLLECT only):
  - Increments every cycle and clears to 0 on byte_stb.
  - When it reaches TIMEOUT_CYC-1 with no byte_stb that cycle: discard the partial word, byte_cnt=0, timeout_err=1, go to IDLE.
  - If byte_stb coincides with the timeout cycle, the byte wins and no timeout occurs.
- Completion, evaluated at the same edge as the final byte capture:
  - word_valid=0: load word_data, set word_valid=1.
  - word_valid=1 and word_ack=1: load the new word_data, word_valid stays 1.
  - word_valid=1 and word_ack=0: drop the new word, keep the old word_data, set overflow=1.
- Handshake:
  - word_ack=1 while word_valid=1 clears word_valid at the next edge, unless a completion reloads it in the same cycle.
  - word_ack while word_valid=0 is ignored.
  - word_data holds its value after ack until the next load.
- Sticky flags:
  - clr_err=1 clears overflow and timeout_err at the next edge.
  - A set event in the same cycle as clr_err wins, so the flag stays 1.
- Assembly continues while word_valid=1, giving one word of buffering plus one partial word.

Test Plan:
- Reset, then rx_dv pulses with bytes 0x11, 0x22, 0x33, 0x44 -> word_data=0x44332211; word_valid rises exactly 2 clk after the 4th rx_dv is first sampled; byte_cnt sequence 1, 2, 3, 0.
- rx_dv held high for 20 clk per byte -> exactly one byte_stb per pulse; word=0x44332211, not a duplicated-lane word.
- Word 0xDDCCBBAA unacked, then 4 more bytes 0x01..0x04 -> overflow=1, word_data stays 0xDDCCBBAA. Repeat with word_ack asserted on the completing cycle -> word_data=0x04030201, word_valid stays 1, overflow=0.
- TIMEOUT_CYC=100: send 0xAA, 0xBB, then idle 100 clk -> byte_cnt=0, timeout_err=1, word_valid=0. Next 4 bytes 0x01..0x04 -> 0x04030201.
- A byte arriving on cycle 99 of the timeout window -> no timeout, byte_cnt increments. clr_err coincident with a new overflow -> overflow remains 1; clr_err alone -> overflow=0.
- Assert rst after 2 bytes, then send 4 bytes 0x05..0x08 -> word_data=0x08070605, no flags set; all outputs read 0 during reset.

Source files
------------

// File: rtl/uart_rx_word_packer.sv
// Packs UART receiver bytes (async rx_dv strobe) little-endian into BIT_WIDTH words for the core.
// Latency: byte captured SYNC_STAGES clk edges after rx_dv is first sampled; word_valid rises on the final capture edge.
// Backpressure: one held word plus one partial; a completed word arriving while unacked is dropped and flags overflow.
module uart_rx_word_packer #(
    parameter int BIT_WIDTH   = 32,
    parameter int BYTES       = BIT_WIDTH / 8,
    parameter int CNT_W       = $clog2(BYTES),
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_dv,
    input  logic [7:0]           rx_byte,
    input  logic                 word_ack,
    input  logic                 clr_err,
    output logic [BIT_WIDTH-1:0] word_data,
    output logic                 word_valid,
    output logic [CNT_W-1:0]     byte_cnt,
    output logic                 overflow,
    output logic                 timeout_err
);

    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] COLLECT = 1'b1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_prev;
    logic                   byte_stb;

    logic [0:0]             state_q;
    logic [0:0]             state_d;
    logic [CNT_W-1:0]       cnt_d;
    logic [TMR_W-1:0]       timer_q;
    logic [TMR_W-1:0]       timer_d;
    logic [BIT_WIDTH-1:0]   asm_q;
    logic [BIT_WIDTH-1:0]   asm_d;

    logic                   last_lane;
    logic                   complete;
    logic                   timeout;
    logic                   load_word;
    logic                   ovf_set;

    // rx_dv is asynchronous: shift it through the synchroniser, then edge-detect the last stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q    <= '0;
            sync_prev <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], rx_dv};
            sync_prev <= sync_q[SYNC_STAGES-1];
        end
    end

    assign byte_stb  = sync_q[SYNC_STAGES-1] & ~sync_prev;
    assign last_lane = (byte_cnt == CNT_W'(BYTES - 1));
    assign complete  = byte_stb & last_lane;
    assign timeout   = (state_q == COLLECT) & ~byte_stb
                     & (timer_q == TMR_W'(TIMEOUT_CYC - 1));
    assign load_word = complete & (~word_valid | word_ack);
    assign ovf_set   = complete & word_valid & ~word_ack;

    always_comb begin
        asm_d = asm_q;
        if (byte_stb) begin
            for (int i = 0; i < BYTES; i++) begin
                if (byte_cnt == CNT_W'(i)) begin
                    asm_d[8*i +: 8] = rx_byte;
                end
            end
        end
    end

    // A byte on the timeout cycle takes priority, so the window restarts instead of discarding.
    always_comb begin
        state_d = state_q;
        cnt_d   = byte_cnt;
        timer_d = timer_q;
        if (complete) begin
            state_d = IDLE;
            cnt_d   = '0;
            timer_d = '0;
        end else if (byte_stb) begin
            state_d = COLLECT;
            cnt_d   = byte_cnt + 1'b1;
            timer_d = '0;
        end else if (timeout) begin
            state_d = IDLE;
            cnt_d   = '0;
            timer_d = '0;
        end else if (state_q == COLLECT) begin
            timer_d = timer_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            byte_cnt <= '0;
            timer_q  <= '0;
            asm_q    <= '0;
        end else begin
            state_q  <= state_d;
            byte_cnt <= cnt_d;
            timer_q  <= timer_d;
            asm_q    <= (complete | timeout) ? '0 : asm_d;
        end
    end

    // The completed word is taken from asm_d so the final byte lands in the same edge it is captured.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_data   <= '0;
            word_valid  <= 1'b0;
            overflow    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if (load_word) begin
                word_data  <= asm_d;
                word_valid <= 1'b1;
            end else if (word_ack) begin
                word_valid <= 1'b0;
            end
            overflow    <= ovf_set | (overflow & ~clr_err);
            timeout_err <= timeout | (timeout_err & ~clr_err);
        end
    end

endmodule

// File: tb/tb_uart_rx_word_packer.sv
// Directed bench for uart_rx_word_packer: queue-based byte/word model compared every cycle, plus literal spot checks.
module tb_uart_rx_word_packer;

    localparam int TO = 100;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_dv;
    logic [7:0]  rx_byte;
    logic        word_ack;
    logic        clr_err;
    logic [31:0] word_data;
    logic        word_valid;
    logic [1:0]  byte_cnt;
    logic        overflow;
    logic        timeout_err;

    int n_checks = 0;
    int n_pass   = 0;

    uart_rx_word_packer #(
        .BIT_WIDTH   (32),
        .SYNC_STAGES (2),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_dv       (rx_dv),
        .rx_byte     (rx_byte),
        .word_ack    (word_ack),
        .clr_err     (clr_err),
        .word_data   (word_data),
        .word_valid  (word_valid),
        .byte_cnt    (byte_cnt),
        .overflow    (overflow),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    endtask

    // Model: a byte is taken two clk edges after rx_dv is first seen high; bytes queue until four make a word.
    logic [7:0]  m_q[$];
    int          m_idle;
    logic [31:0] m_word;
    logic        m_valid, m_ovf, m_terr;
    logic        h1, h2, h3;
    logic        m_stb, m_loaded, m_ovf_set, m_to_set;

    always @(posedge clk) begin
        if (rst) begin
            m_q.delete();
            m_idle  = 0;
            m_word  = '0;
            m_valid = 1'b0;
            m_ovf   = 1'b0;
            m_terr  = 1'b0;
            h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
        end else begin
            m_stb = h2 && !h3;
            m_loaded = 1'b0; m_ovf_set = 1'b0; m_to_set = 1'b0;
            if (m_stb) begin
                m_q.push_back(rx_byte);
                m_idle = 0;
                if (m_q.size() == 4) begin
                    if (!m_valid || word_ack) begin
                        m_word   = {m_q[3], m_q[2], m_q[1], m_q[0]};
                        m_valid  = 1'b1;
                        m_loaded = 1'b1;
                    end else begin
                        m_ovf_set = 1'b1;
                    end
                    m_q.delete();
                end
            end else if (m_q.size() > 0) begin
                m_idle++;
                if (m_idle == TO) begin
                    m_q.delete();
                    m_idle   = 0;
                    m_to_set = 1'b1;
                end
            end
            if (!m_loaded && word_ack) m_valid = 1'b0;
            m_ovf  = m_ovf_set || (m_ovf && !clr_err);
            m_terr = m_to_set || (m_terr && !clr_err);
            h3 = h2; h2 = h1; h1 = rx_dv;
        end
    end

    always @(negedge clk) begin
        check("word_data",   word_data,           m_word);
        check("word_valid",  32'(word_valid),     32'(m_valid));
        check("byte_cnt",    32'(byte_cnt),       m_q.size());
        check("overflow",    32'(overflow),       32'(m_ovf));
        check("timeout_err", 32'(timeout_err),    32'(m_terr));
    end

    task automatic send_byte(input logic [7:0] b, input int hold);
        rx_byte = b;
        rx_dv   = 1'b1;
        repeat (hold) @(negedge clk);
        rx_dv = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic pulse_ack();
        word_ack = 1'b1;
        @(negedge clk);
        word_ack = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        @(negedge clk);
    endtask

    // Sends the last byte of a word with ack/clr driven high in the cycle before the completing edge.
    task automatic send_last(input logic [7:0] b, input logic ack, input logic clr);
        rx_byte = b;
        rx_dv   = 1'b1;
        @(negedge clk);
        rx_dv = 1'b0;
        @(negedge clk);
        word_ack = ack;
        clr_err  = clr;
        @(negedge clk);
        word_ack = 1'b0;
        clr_err  = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rx_dv = 1'b0; rx_byte = 8'h00; word_ack = 1'b0; clr_err = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_data",  word_data, 32'h0);
        check("rst_valid", 32'(word_valid), 32'h0);
        check("rst_cnt",   32'(byte_cnt), 32'h0);
        check("rst_ovf",   32'(overflow), 32'h0);
        check("rst_terr",  32'(timeout_err), 32'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Basic word and latency of the final byte
        send_byte(8'h11, 1); check("cnt_seq1", 32'(byte_cnt), 32'd1);
        send_byte(8'h22, 1); check("cnt_seq2", 32'(byte_cnt), 32'd2);
        send_byte(8'h33, 1); check("cnt_seq3", 32'(byte_cnt), 32'd3);
        rx_byte = 8'h44; rx_dv = 1'b1;
        @(negedge clk); rx_dv = 1'b0;
        check("lat_edge0_valid", 32'(word_valid), 32'h0);
        @(negedge clk);
        check("lat_edge1_valid", 32'(word_valid), 32'h0);
        @(negedge clk);
        check("lat_edge2_valid", 32'(word_valid), 32'h1);
        check("word_basic", word_data, 32'h44332211);
        check("cnt_seq4", 32'(byte_cnt), 32'd0);
        repeat (2) @(negedge clk);
        pulse_ack();
        check("ack_clears_valid", 32'(word_valid), 32'h0);
        check("data_held_after_ack", word_data, 32'h44332211);

        // Long rx_dv pulses give one byte each
        send_byte(8'h11, 20); send_byte(8'h22, 20); send_byte(8'h33, 20); send_byte(8'h44, 20);
        check("word_long_pulse", word_data, 32'h44332211);
        check("valid_long_pulse", 32'(word_valid), 32'h1);
        pulse_ack();

        // Overflow drops the new word
        send_byte(8'hAA, 1); send_byte(8'hBB, 1); send_byte(8'hCC, 1); send_byte(8'hDD, 1);
        send_byte(8'h01, 1); send_byte(8'h02, 1); send_byte(8'h03, 1); send_byte(8'h04, 1);
        check("ovf_set", 32'(overflow), 32'h1);
        check("ovf_data_kept", word_data, 32'hDDCCBBAA);
        pulse_clr();
        check("ovf_cleared", 32'(overflow), 32'h0);
        // Ack on the completing cycle reloads without overflow
        send_byte(8'h01, 1); send_byte(8'h02, 1); send_byte(8'h03, 1);
        send_last(8'h04, 1'b1, 1'b0);
        check("ack_reload_data", word_data, 32'h04030201);
        check("ack_reload_valid", 32'(word_valid), 32'h1);
        check("ack_reload_no_ovf", 32'(overflow), 32'h0);
        pulse_ack();

        // Inter-byte timeout discards the partial word
        send_byte(8'hAA, 1); send_byte(8'hBB, 1);
        repeat (TO + 5) @(negedge clk);
        check("to_cnt", 32'(byte_cnt), 32'd0);
        check("to_flag", 32'(timeout_err), 32'h1);
        check("to_valid", 32'(word_valid), 32'h0);
        send_byte(8'h01, 1); send_byte(8'h02, 1); send_byte(8'h03, 1); send_byte(8'h04, 1);
        check("after_to_word", word_data, 32'h04030201);
        pulse_ack();
        pulse_clr();
        check("to_cleared", 32'(timeout_err), 32'h0);

        // Byte captured on the last cycle of the window beats the timeout
        send_byte(8'hAA, 1);
        repeat (TO - 4) @(negedge clk);
        send_byte(8'hBB, 1);
        check("edge_to_cnt", 32'(byte_cnt), 32'd2);
        check("edge_to_flag", 32'(timeout_err), 32'h0);
        send_byte(8'hCC, 1); send_byte(8'hDD, 1);
        check("edge_to_word", word_data, 32'hDDCCBBAA);

        // Overflow set coincident with clr_err stays set
        send_byte(8'h01, 1); send_byte(8'h02, 1); send_byte(8'h03, 1);
        send_last(8'h04, 1'b0, 1'b1);
        check("ovf_beats_clr", 32'(overflow), 32'h1);
        pulse_clr();
        check("clr_alone", 32'(overflow), 32'h0);
        pulse_ack();

        // Reset mid-word
        send_byte(8'h01, 1); send_byte(8'h02, 1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_data",  word_data, 32'h0);
        check("midrst_cnt",   32'(byte_cnt), 32'h0);
        check("midrst_valid", 32'(word_valid), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send_byte(8'h05, 1); send_byte(8'h06, 1); send_byte(8'h07, 1); send_byte(8'h08, 1);
        check("post_rst_word", word_data, 32'h08070605);
        check("post_rst_ovf",  32'(overflow), 32'h0);
        check("post_rst_terr", 32'(timeout_err), 32'h0);
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
